// File: rtl/tc_program8_loader.sv
// tc_program8_loader: streams ADDR/LEN/DATA.../CHK packets into a byte-wide program store read combinationally by address.
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset (memory contents preserved)
//   in_valid - loader byte offered
//   in_data  - loader byte
//   in_ready - byte accepted this cycle (low only in FIN)
//   address  - program read address
//   out      - program byte at address (0 while rst)
//   busy     - packet in progress past its first header byte
//   done     - one-cycle pulse when a packet finishes
//   err      - sticky checksum mismatch of the last packet
module tc_program8_loader #(
  parameter int UUID = 0,
  parameter NAME = "",
  parameter int BIT_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic [7:0] address,
  output logic [7:0] out,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {H_ADDR, H_LEN, DATA, CHK, FIN} state_t;
  state_t state, state_nx;
  logic [7:0] mem [BIT_DEPTH];
  logic [7:0] wptr, sum;
  logic [8:0] count;
  logic beat;
  assign beat = in_valid && in_ready;
  always_ff @(posedge clk) state <= rst ? H_ADDR : state_nx;
  // count holds the bytes still due, so the beat that sees 1 is the last data byte
  always_comb begin
    state_nx = state == FIN    ? H_ADDR :
               !beat           ? state :
               state == H_ADDR ? H_LEN :
               state == H_LEN  ? DATA :
               state == DATA   ? (count == 9'd1 ? CHK : DATA) : FIN;
  end
  always_comb begin
    in_ready = state != FIN;
    busy     = state != H_ADDR;
    done     = state == FIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      err   <= 1'b0;
      wptr  <= '0;
      count <= '0;
      sum   <= '0;
    end else if (beat) begin
      if (state == H_ADDR) begin
        wptr <= in_data;
        sum  <= '0;
      end
      if (state == H_LEN) count <= in_data == 8'd0 ? 9'd256 : {1'b0, in_data};
      if (state == DATA) begin
        wptr  <= wptr + 8'd1;
        count <= count - 9'd1;
        sum   <= sum + in_data;
      end
      if (state == CHK) err <= in_data != sum;
    end
  end
  // bytes aimed past BIT_DEPTH are consumed but dropped
  always_ff @(posedge clk) begin
    if (!rst && beat && state == DATA && 32'(wptr) < BIT_DEPTH) mem[wptr] <= in_data;
  end
  assign out = rst ? 8'd0 : 32'(address) < BIT_DEPTH ? mem[address] : 8'd0;
endmodule

// File: tb/tb_tc_program8_loader.sv
// tb_tc_program8_loader: scoreboard bench for the packet program loader.
module tb_tc_program8_loader;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, busy, done, err;
  logic [7:0] in_data = 0, address = 0, out;
  typedef logic [7:0] bq_t[$];
  typedef struct {logic [7:0] a; logic [7:0] d;} ent_t;
  ent_t sb[$];
  int checks = 0, errors = 0, stray = 0;
  tc_program8_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .address(address), .out(out), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // called at a negedge; returns at the negedge after the beat edge
  task automatic send(input logic [7:0] b, input bit rnd, input logic exp_busy);
    if (rnd) begin
      int g = $urandom_range(2, 0);
      for (int i = 0; i < g; i++) begin
        in_valid = 0;
        @(negedge clk);
        chk("gap_busy", busy, exp_busy);
      end
    end
    if (!in_ready) stray++;
    if (done) stray++;
    in_valid = 1;
    in_data = b;
    @(negedge clk);
  endtask
  task automatic pkt(input bq_t b, input bit rnd, input logic exp_err);
    int len = b[1] == 0 ? 256 : int'(b[1]);
    stray = 0;
    for (int i = 0; i < len; i++) sb.push_back('{b[0] + 8'(i), b[2 + i]});
    for (int i = 0; i < b.size(); i++) send(b[i], rnd, i != 0);
    chk("stray", stray, 0);
    chk("done_fin", done, 1);
    chk("ready_fin", in_ready, 0);
    chk("busy_fin", busy, 1);
    chk("err", err, exp_err);
    in_valid = 0;
    @(negedge clk);
    chk("done_low", done, 0);
    chk("busy_idle", busy, 0);
    chk("ready_idle", in_ready, 1);
  endtask
  task automatic drain();
    ent_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      address = e.a;
      #1;
      chk("mem", out, e.d);
      @(negedge clk);
    end
  endtask
  bq_t p;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_out", out, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_rel", in_ready, 1);
    p = {8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31};
    pkt(p, 0, 0);
    drain();
    address = 8'h11;
    #1 chk("addr11", out, 8'hBB);
    @(negedge clk);
    p = {8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06};
    pkt(p, 0, 0);
    drain();
    p = {8'h20, 8'h02, 8'h01, 8'h02, 8'h00};
    pkt(p, 0, 1);
    drain();
    p = {8'h30, 8'h01, 8'h05, 8'h05};
    pkt(p, 0, 0);
    drain();
    p = {8'h00, 8'h00};
    for (int i = 0; i < 256; i++) p.push_back(8'h01);
    p.push_back(8'h00);
    pkt(p, 0, 0);
    drain();
    stray = 0;
    sb.push_back('{8'h40, 8'hD0});
    sb.push_back('{8'h41, 8'hD1});
    sb.push_back('{8'h42, 8'h01});
    sb.push_back('{8'h43, 8'h01});
    send(8'h40, 0, 0);
    send(8'h04, 0, 1);
    send(8'hD0, 0, 1);
    send(8'hD1, 0, 1);
    chk("mid_busy", busy, 1);
    rst = 1;
    in_data = 8'hD2;
    address = 8'h40;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_err", err, 0);
    chk("rst_mid_out", out, 0);
    @(negedge clk);
    chk("rst_hold_busy", busy, 0);
    rst = 0;
    in_valid = 0;
    @(negedge clk);
    chk("rst_stray", stray, 0);
    drain();
    p = {8'h50, 8'h01, 8'h77, 8'h77};
    pkt(p, 0, 0);
    drain();
    p = {8'h40, 8'h02, 8'h09, 8'h0A, 8'h13};
    pkt(p, 1, 0);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
